median_win_seq: RTL and testbench

- Sequencer sitting between the pixel counter controller and the 3x3 median sorter.
- For each centre pixel (1-based row/column from the counter) it fetches the 9 window pixels from frame memory through a req/ack read port, clamping at image borders (replicate edge).
- It presents the packed window to the sorter with a valid/ready handshake, then requests the next centre pixel, until the frame is complete.

---
 rtl/median_win_seq.sv | 165 ++++++++++++++++
 tb/tb_median_win_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_win_seq.sv
// Window fetch sequencer: walks the 3x3 neighbourhood of each centre pixel through
// a req/ack frame-memory port (edge-replicated) and hands the packed window to the sorter.
module median_win_seq #(
  parameter int DW = 8,
  parameter int AW = 18
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start_sig,
  input  logic [9:0]      rows,
  input  logic [9:0]      cols,
  output logic            cnt_start_sig,
  input  logic            pix_done_sig,
  input  logic [9:0]      row_addr_sig,
  input  logic [9:0]      column_addr_sig,
  output logic            nxt_pix_sig,
  output logic            rd_req,
  output logic [AW-1:0]   rd_addr,
  input  logic            rd_ack,
  input  logic [DW-1:0]   rd_data,
  output logic [9*DW-1:0] win_data,
  output logic            win_vld,
  input  logic            win_rdy,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_WAIT, S_FETCH, S_OUT, S_ADV, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic          start_p1;
  logic          start_rise;
  logic [9:0]    rows_q, cols_q;
  logic [9:0]    ctr_r, ctr_c;
  logic [3:0]    k;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] tap [9];
  logic          last_tap;
  logic          last_pix;
  logic          idle_like;

  // Offset index 0/1/2 stands for -1/0/+1 around the centre.
  function automatic logic [1:0] tap_row_off(input logic [3:0] kk);
    case (kk)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_col_off(input logic [3:0] kk);
    case (kk)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  // Saturate (ctr + off - 1) into 1..lim; computed at 11 bits so ctr+2 cannot wrap.
  function automatic logic [9:0] clamp_idx(input logic [9:0] ctr,
                                           input logic [1:0] off,
                                           input logic [9:0] lim);
    logic [10:0] t;
    t = {1'b0, ctr} + {9'd0, off};
    if (t <= 11'd1)
      return 10'd1;
    else if ((t - 11'd1) > {1'b0, lim})
      return lim;
    else
      return 10'(t - 11'd1);
  endfunction

  function automatic logic [AW-1:0] tap_addr(input logic [9:0] rc,
                                             input logic [9:0] cc,
                                             input logic [3:0] kk,
                                             input logic [9:0] nr,
                                             input logic [9:0] nc);
    logic [9:0]  r, c;
    logic [19:0] prod;
    logic [20:0] sum;
    r    = clamp_idx(rc, tap_row_off(kk), nr);
    c    = clamp_idx(cc, tap_col_off(kk), nc);
    prod = {10'd0, r - 10'd1} * {10'd0, nc};
    sum  = {1'b0, prod} + {11'd0, c - 10'd1};
    return AW'(sum);
  endfunction

  assign start_rise = start_sig & ~start_p1;
  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign last_tap   = (k == 4'd8);
  assign last_pix   = (ctr_r == rows_q) && (ctr_c == cols_q);
  assign rd_addr    = addr_q;

  always_ff @(posedge CLK) begin
    if (RST)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_rise) state_nxt = S_KICK;
      S_KICK:         state_nxt = S_WAIT;
      S_WAIT:         if (pix_done_sig) state_nxt = S_FETCH;
      S_FETCH:        if (rd_ack && last_tap) state_nxt = S_OUT;
      S_OUT:          if (win_rdy) state_nxt = last_pix ? S_DONE : S_ADV;
      S_ADV:          state_nxt = S_WAIT;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_start_sig = (state == S_KICK);
    nxt_pix_sig   = (state == S_ADV);
    rd_req        = (state == S_FETCH);
    win_vld       = (state == S_OUT);
    frame_done    = (state == S_DONE);
    busy          = !idle_like;
  end

  // Frame geometry, centre latch, tap index and the registered read address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      start_p1 <= 1'b0;
      rows_q   <= '0;
      cols_q   <= '0;
      ctr_r    <= '0;
      ctr_c    <= '0;
      k        <= '0;
      addr_q   <= '0;
      for (int i = 0; i < 9; i++) tap[i] <= '0;
    end else begin
      start_p1 <= start_sig;
      if (idle_like && start_rise) begin
        rows_q <= rows;
        cols_q <= cols;
      end
      if (state == S_WAIT && pix_done_sig) begin
        ctr_r  <= row_addr_sig;
        ctr_c  <= column_addr_sig;
        k      <= 4'd0;
        addr_q <= tap_addr(row_addr_sig, column_addr_sig, 4'd0, rows_q, cols_q);
      end
      if (state == S_FETCH && rd_ack) begin
        for (int i = 0; i < 9; i++)
          if (k == 4'(i)) tap[i] <= rd_data;
        if (!last_tap) begin
          k      <= k + 4'd1;
          addr_q <= tap_addr(ctr_r, ctr_c, k + 4'd1, rows_q, cols_q);
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++)
      win_data[DW*i +: DW] = tap[i];
  end

endmodule

// File: tb/tb_median_win_seq.sv
// Directed bench for median_win_seq with a pixel-counter model and a frame memory
// whose word at address i is i[7:0].
module tb_median_win_seq;
  localparam int DW = 8;
  localparam int AW = 18;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start_sig;
  logic [9:0]      rows, cols;
  logic            cnt_start_sig;
  logic            pix_done_sig;
  logic [9:0]      row_addr_sig, column_addr_sig;
  logic            nxt_pix_sig;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_ack;
  logic [DW-1:0]   rd_data;
  logic [9*DW-1:0] win_data;
  logic            win_vld;
  logic            win_rdy;
  logic            busy;
  logic            frame_done;

  median_win_seq #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .start_sig(start_sig), .rows(rows), .cols(cols),
    .cnt_start_sig(cnt_start_sig), .pix_done_sig(pix_done_sig),
    .row_addr_sig(row_addr_sig), .column_addr_sig(column_addr_sig),
    .nxt_pix_sig(nxt_pix_sig), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .win_data(win_data), .win_vld(win_vld),
    .win_rdy(win_rdy), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          r;
    int          c;
    logic [71:0] win;
  } vec_t;

  vec_t          tbl [9];
  int            n_cmp = 0, n_fail = 0;
  int            n_kick = 0, n_nxt = 0, n_req = 0;
  int            b_kick, b_nxt, b_req;
  int            dly = 0, cr = 0, cc = 0, f_rows = 1, f_cols = 1;
  bit            rnd_dly = 1'b0;
  logic          p_req = 1'b0, p_ack = 1'b0, p_vld = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [71:0]   p_win = '0;
  logic [71:0]   win_q [$];
  logic [AW-1:0] addr_q [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {t8[7:0], t7[7:0], t6[7:0], t5[7:0], t4[7:0], t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input int nr, input int nc);
    logic [71:0] w;
    int rr, c2, a;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      c2 = c + k % 3 - 1;
      if (rr < 1) rr = 1;
      if (rr > nr) rr = nr;
      if (c2 < 1) c2 = 1;
      if (c2 > nc) c2 = nc;
      a = (rr - 1) * nc + (c2 - 1);
      w[8*k +: 8] = a[7:0];
    end
    return w;
  endfunction

  // One clock: sample at the falling edge, then drive counter and memory responses.
  task automatic step();
    @(negedge CLK);
    if (!RST && p_req && !p_ack && rd_req) check("addr_stable", rd_addr, p_addr);
    if (!RST && p_vld && !win_rdy) begin
      check("vld_hold", win_vld, 1'b1);
      check("win_hold", win_data, p_win);
    end
    if (!RST && p_vld && win_rdy) win_q.push_back(p_win);
    if (cnt_start_sig) n_kick++;
    if (nxt_pix_sig) n_nxt++;
    if (rd_req) n_req++;
    if (RST) begin
      pix_done_sig = 1'b0;
    end else if (cnt_start_sig) begin
      cr = 1; cc = 1; pix_done_sig = 1'b1;
    end else if (nxt_pix_sig) begin
      cc++;
      if (cc > f_cols) begin cc = 1; cr++; end
    end
    row_addr_sig    = 10'(cr);
    column_addr_sig = 10'(cc);
    if (rd_req && !RST) begin
      if (dly == 0) begin
        rd_ack  = 1'b1;
        rd_data = rd_addr[7:0];
        addr_q.push_back(rd_addr);
        dly = rnd_dly ? int'($urandom_range(0, 5)) : 0;
      end else begin
        rd_ack = 1'b0;
        dly--;
      end
    end else begin
      rd_ack = 1'b0;
      if (RST) dly = 0;
    end
    p_req = rd_req; p_ack = rd_ack; p_addr = rd_addr; p_vld = win_vld; p_win = win_data;
  endtask

  task automatic setup(input int nr, input int nc, input bit rnd);
    f_rows = nr; f_cols = nc;
    rows = 10'(nr); cols = 10'(nc);
    rnd_dly = rnd;
    win_q.delete(); addr_q.delete();
    b_kick = n_kick; b_nxt = n_nxt; b_req = n_req;
  endtask

  task automatic run_frame(input int nr, input int nc, input bit rnd, output int cyc);
    setup(nr, nc, rnd);
    start_sig = 1'b1;
    step();
    start_sig = 1'b0;
    cyc = 1;
    while (!frame_done && cyc < 3000) begin
      step();
      cyc++;
    end
    check($sformatf("frame_done_%0dx%0d", nr, nc), frame_done, 1'b1);
  endtask

  task automatic check_outs_zero(input string nm);
    check(nm, {cnt_start_sig, nxt_pix_sig, rd_req, rd_addr, win_data, win_vld, busy, frame_done}, '0);
  endtask

  task automatic check_3x3_windows(input string tag);
    check({tag, "_count"}, win_q.size(), 9);
    for (int i = 0; i < 9 && i < win_q.size(); i++)
      check($sformatf("%s_win_r%0dc%0d", tag, tbl[i].r, tbl[i].c), win_q[i], tbl[i].win);
  endtask

  initial begin
    int cyc, t, kick0, nxt0;
    logic [71:0] w0;
    int exp_last [9];

    tbl[0] = '{1, 1, pack9(0, 0, 1, 0, 0, 1, 3, 3, 4)};
    tbl[1] = '{1, 2, pack9(0, 1, 2, 0, 1, 2, 3, 4, 5)};
    tbl[2] = '{1, 3, pack9(1, 2, 2, 1, 2, 2, 4, 5, 5)};
    tbl[3] = '{2, 1, pack9(0, 0, 1, 3, 3, 4, 6, 6, 7)};
    tbl[4] = '{2, 2, pack9(0, 1, 2, 3, 4, 5, 6, 7, 8)};
    tbl[5] = '{2, 3, pack9(1, 2, 2, 4, 5, 5, 7, 8, 8)};
    tbl[6] = '{3, 1, pack9(3, 3, 4, 6, 6, 7, 6, 6, 7)};
    tbl[7] = '{3, 2, pack9(3, 4, 5, 6, 7, 8, 6, 7, 8)};
    tbl[8] = '{3, 3, pack9(4, 5, 5, 7, 8, 8, 7, 8, 8)};
    exp_last = '{13, 14, 14, 18, 19, 19, 18, 19, 19};

    RST = 1'b1; start_sig = 1'b0; rows = '0; cols = '0; pix_done_sig = 1'b0;
    row_addr_sig = '0; column_addr_sig = '0; rd_ack = 1'b0; rd_data = '0; win_rdy = 1'b1;
    repeat (3) step();
    check_outs_zero("rst_init");
    RST = 1'b0;
    step();

    // 3x3 frame, zero-wait memory and sorter
    run_frame(3, 3, 1'b0, cyc);
    check("cycles_3x3", cyc, 109);
    check_3x3_windows("f3x3");
    check("nxt_pulses_3x3", n_nxt - b_nxt, 8);
    check("kick_pulses_3x3", n_kick - b_kick, 1);
    check("req_cycles_3x3", n_req - b_req, 81);
    check("busy_done_3x3", busy, 1'b0);
    repeat (5) step();
    check("no_extra_win", win_q.size(), 9);

    // 4x5 frame with random memory latency
    run_frame(4, 5, 1'b1, cyc);
    check("count_4x5", win_q.size(), 20);
    check("taps_4x5", addr_q.size(), 180);
    for (int i = 0; i < win_q.size(); i++)
      check($sformatf("win4x5_%0d", i), win_q[i], exp_win(i / 5 + 1, i % 5 + 1, 4, 5));
    if (addr_q.size() >= 9)
      for (int j = 0; j < 9; j++)
        check($sformatf("addr_4x5_last_%0d", j), addr_q[addr_q.size() - 9 + j], exp_last[j]);
    if (win_q.size() > 0)
      check("win4x5_corner11", win_q[0], pack9(0, 0, 1, 0, 0, 1, 5, 5, 6));
    check("nxt_pulses_4x5", n_nxt - b_nxt, 19);

    // Single-row image: vertical taps collapse onto row 1
    run_frame(1, 3, 1'b0, cyc);
    check("count_1x3", win_q.size(), 3);
    if (win_q.size() == 3) begin
      check("win1x3_c1", win_q[0], pack9(0, 0, 1, 0, 0, 1, 0, 0, 1));
      for (int i = 1; i < 3; i++)
        check($sformatf("win1x3_c%0d", i + 1), win_q[i], exp_win(1, i + 1, 1, 3));
    end

    // Sorter stalls on the first window, then start toggles mid-fetch
    setup(3, 3, 1'b0);
    win_rdy = 1'b0;
    start_sig = 1'b1; step(); start_sig = 1'b0;
    t = 0;
    while (!win_vld && t < 200) begin step(); t++; end
    check("stall_vld_seen", win_vld, 1'b1);
    w0 = win_data; nxt0 = n_nxt;
    repeat (10) step();
    check("stall_vld", win_vld, 1'b1);
    check("stall_data", win_data, w0);
    check("stall_no_nxt", n_nxt - nxt0, 0);
    check("stall_win_value", w0, tbl[0].win);
    win_rdy = 1'b1;
    t = 0;
    while (!rd_req && t < 50) begin step(); t++; end
    check("refetch_seen", rd_req, 1'b1);
    kick0 = n_kick;
    start_sig = 1'b1; step(); step(); start_sig = 1'b0; step();
    t = 0;
    while (!frame_done && t < 400) begin step(); t++; end
    check("frame_done_stall", frame_done, 1'b1);
    check("start_ignored", n_kick - kick0, 0);
    check_3x3_windows("stall");

    // Restart from DONE
    setup(3, 3, 1'b0);
    start_sig = 1'b1; step(); start_sig = 1'b0; step();
    check("restart_done_clr", frame_done, 1'b0);
    check("restart_busy", busy, 1'b1);
    check("restart_kick", n_kick - b_kick, 1);
    t = 0;
    while (!frame_done && t < 400) begin step(); t++; end
    check("frame_done_restart", frame_done, 1'b1);
    check_3x3_windows("restart");
    check("restart_kick_total", n_kick - b_kick, 1);

    // Reset in the middle of a fetch
    setup(3, 3, 1'b1);
    start_sig = 1'b1; step(); start_sig = 1'b0;
    t = 0;
    while (!rd_req && t < 50) begin step(); t++; end
    check("fetch_seen", rd_req, 1'b1);
    RST = 1'b1;
    step();
    check_outs_zero("rst_fetch");
    step(); step();
    RST = 1'b0;
    step(); step();
    check_outs_zero("idle_after_rst");
    run_frame(3, 3, 1'b0, cyc);
    check("cycles_after_rst", cyc, 109);
    check_3x3_windows("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
